// File: rtl/start_screen_pixel.sv
// Start-screen pixel stage: title image lookup, blinking prompt band and start countdown.
// Optional feature: define START_BLINK_EN to make the prompt band blink (otherwise always yellow).
module start_screen_pixel #(
  parameter logic [10:0] IMG_X0       = 11'd201,
  parameter logic [10:0] IMG_Y0       = 11'd102,
  parameter int          IMG_W        = 256,
  parameter int          IMG_H        = 253,
  parameter int          ADDR_W       = 16,
  parameter logic [10:0] PROMPT_Y0    = 11'd300,
  parameter logic [10:0] PROMPT_Y1    = 11'd330,
  parameter int          BLINK_FRAMES = 30,
  parameter int          COUNT_FRAMES = 60
) (
  input  logic              CLK_40M,
  input  logic              RSTn,
  input  logic              start_Ready_sig,
  input  logic              start_Hsync_sig,
  input  logic              start_Vsync_sig,
  input  logic [10:0]       Row_add,
  input  logic [10:0]       Column_add,
  input  logic              key_start,
  input  logic              game_over,
  input  logic              rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [4:0]        Red_sig,
  output logic [5:0]        Green_sig,
  output logic [4:0]        Blue_sig,
  output logic              Hsync_out,
  output logic              Vsync_out,
  output logic              game_start,
  output logic              start_active
);

  localparam logic [1:0] S_SHOW   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_HIDDEN = 2'd2;

  localparam int CNT_W = $clog2((COUNT_FRAMES > BLINK_FRAMES) ? COUNT_FRAMES : BLINK_FRAMES);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] COUNT_LAST = CNT_W'(COUNT_FRAMES - 1);
  localparam logic [11:0] X_END = 12'(IMG_X0) + 12'(IMG_W);
  localparam logic [11:0] Y_END = 12'(IMG_Y0) + 12'(IMG_H);

  localparam logic [15:0] C_WHITE  = {5'h1F, 6'h3F, 5'h1F};
  localparam logic [15:0] C_YELLOW = {5'h1F, 6'h3F, 5'h00};
  localparam logic [15:0] C_BG     = {5'h00, 6'h00, 5'h0C};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_frameCnt;
  logic              r_vsPrev;
  logic              r_inImg1, r_prompt1, r_blink1, r_hidden1;
  logic              r_inImg2, r_prompt2, r_blink2, r_hidden2;
  logic [1:0]        r_readyDly;
  logic [2:0]        r_hsDly, r_vsDly;
  logic [15:0]       r_rgb;

  logic              w_inImg, w_inPrompt, w_tick, w_blinkOn, w_gameStartNext;
  logic [10:0]       w_rowOff, w_colOff;
  logic [ADDR_W-1:0] w_romAddr;
  logic [1:0]        w_nextState;
  logic [CNT_W-1:0]  w_nextCnt;

  assign w_inImg = start_Ready_sig
                && (Column_add >= IMG_X0) && ({1'b0, Column_add} < X_END)
                && (Row_add >= IMG_Y0)    && ({1'b0, Row_add} < Y_END);
  assign w_inPrompt = (Row_add >= PROMPT_Y0) && (Row_add <= PROMPT_Y1);
  assign w_rowOff   = Row_add - IMG_Y0;
  assign w_colOff   = Column_add - IMG_X0;
  assign w_romAddr  = ADDR_W'(22'(w_rowOff) * 22'(IMG_W) + 22'(w_colOff));
  assign w_tick     = r_vsPrev & ~start_Vsync_sig;

  // A start key coinciding with a frame tick wins: the tick is dropped.
  always_comb begin
    w_nextState     = r_state;
    w_nextCnt       = r_frameCnt;
    w_gameStartNext = 1'b0;
    case (r_state)
      S_SHOW: begin
        if (key_start) begin
          w_nextState = S_COUNT;
          w_nextCnt   = '0;
        end else if (w_tick) begin
          w_nextCnt = (r_frameCnt == BLINK_LAST) ? '0 : r_frameCnt + CNT_W'(1);
        end
      end
      S_COUNT: begin
        if (w_tick) begin
          if (r_frameCnt == COUNT_LAST) begin
            w_nextState     = S_HIDDEN;
            w_nextCnt       = '0;
            w_gameStartNext = 1'b1;
          end else begin
            w_nextCnt = r_frameCnt + CNT_W'(1);
          end
        end
      end
      S_HIDDEN: begin
        if (game_over) begin
          w_nextState = S_SHOW;
          w_nextCnt   = '0;
        end
      end
      default: begin
        w_nextState = S_SHOW;
        w_nextCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_SHOW;
      r_frameCnt   <= '0;
      r_vsPrev     <= 1'b0;
      game_start   <= 1'b0;
      start_active <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_frameCnt   <= w_nextCnt;
      r_vsPrev     <= start_Vsync_sig;
      game_start   <= w_gameStartNext;
      start_active <= (w_nextState != S_HIDDEN);
    end
  end

`ifdef START_BLINK_EN
  logic r_blinkOn;

  // COUNT blinks every 4 frames, taken from the low bits of the countdown counter.
  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      r_blinkOn <= 1'b1;
    end else begin
      case (r_state)
        S_SHOW: begin
          if (key_start)
            r_blinkOn <= 1'b1;
          else if (w_tick && (r_frameCnt == BLINK_LAST))
            r_blinkOn <= ~r_blinkOn;
        end
        S_COUNT: begin
          if (w_tick && (r_frameCnt != COUNT_LAST) && (r_frameCnt[1:0] == 2'b11))
            r_blinkOn <= ~r_blinkOn;
        end
        S_HIDDEN: begin
          if (game_over)
            r_blinkOn <= 1'b1;
        end
        default: r_blinkOn <= 1'b1;
      endcase
    end
  end

  assign w_blinkOn = r_blinkOn;
`else
  assign w_blinkOn = 1'b1;
`endif

  // Three-stage pixel pipe: address/flags, ROM read, colour register.
  always_ff @(posedge CLK_40M or negedge RSTn) begin
    if (!RSTn) begin
      rom_addr   <= '0;
      r_inImg1   <= 1'b0;
      r_prompt1  <= 1'b0;
      r_blink1   <= 1'b0;
      r_hidden1  <= 1'b0;
      r_inImg2   <= 1'b0;
      r_prompt2  <= 1'b0;
      r_blink2   <= 1'b0;
      r_hidden2  <= 1'b0;
      r_readyDly <= '0;
      r_hsDly    <= '0;
      r_vsDly    <= '0;
      r_rgb      <= '0;
    end else begin
      if (w_inImg)
        rom_addr <= w_romAddr;
      r_inImg1   <= w_inImg;
      r_prompt1  <= w_inPrompt;
      r_blink1   <= w_blinkOn;
      r_hidden1  <= (r_state == S_HIDDEN);
      r_inImg2   <= r_inImg1;
      r_prompt2  <= r_prompt1;
      r_blink2   <= r_blink1;
      r_hidden2  <= r_hidden1;
      r_readyDly <= {r_readyDly[0], start_Ready_sig};
      r_hsDly    <= {r_hsDly[1:0], start_Hsync_sig};
      r_vsDly    <= {r_vsDly[1:0], start_Vsync_sig};
      if (!r_readyDly[1] || r_hidden2)
        r_rgb <= '0;
      else if (rom_data && r_inImg2)
        r_rgb <= !r_prompt2 ? C_WHITE : (r_blink2 ? C_YELLOW : C_BG);
      else
        r_rgb <= C_BG;
    end
  end

  assign Red_sig   = r_rgb[15:11];
  assign Green_sig = r_rgb[10:5];
  assign Blue_sig  = r_rgb[4:0];
  assign Hsync_out = r_hsDly[2];
  assign Vsync_out = r_vsDly[2];

endmodule

// File: tb/tb_start_screen_pixel.sv
// Testbench for start_screen_pixel: random pixels and frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_start_screen_pixel;

  localparam int IMG_X0 = 201;
  localparam int IMG_Y0 = 102;
  localparam int IMG_W = 256;
  localparam int IMG_H = 253;
  localparam int PROMPT_Y0 = 300;
  localparam int PROMPT_Y1 = 330;
  localparam int BLINK_FRAMES = 30;
  localparam int COUNT_FRAMES = 60;
  localparam int M_SHOW = 0;
  localparam int M_COUNT = 1;
  localparam int M_HIDDEN = 2;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_BG = 16'h000C;

  typedef struct packed {
    logic [15:0] rgb;
    logic        hs;
    logic        vs;
  } pipeEntry_t;

  logic        CLK_40M;
  logic        RSTn;
  logic        start_Ready_sig, start_Hsync_sig, start_Vsync_sig;
  logic [10:0] Row_add, Column_add;
  logic        key_start, game_over, rom_data;
  logic [15:0] rom_addr;
  logic [4:0]  Red_sig;
  logic [5:0]  Green_sig;
  logic [4:0]  Blue_sig;
  logic        Hsync_out, Vsync_out, game_start, start_active;

  bit          romImg [0:65535];

  int          compareCount;
  int          failCount;
  int          mState, mShowTicks, mCountTicks;
  bit          mBlink, mPrevVs, expGameStart, expActive;
  logic [15:0] mAddr;
  pipeEntry_t  pipeQ[$];

  start_screen_pixel dut (
    .CLK_40M         (CLK_40M),
    .RSTn            (RSTn),
    .start_Ready_sig (start_Ready_sig),
    .start_Hsync_sig (start_Hsync_sig),
    .start_Vsync_sig (start_Vsync_sig),
    .Row_add         (Row_add),
    .Column_add      (Column_add),
    .key_start       (key_start),
    .game_over       (game_over),
    .rom_data        (rom_data),
    .rom_addr        (rom_addr),
    .Red_sig         (Red_sig),
    .Green_sig       (Green_sig),
    .Blue_sig        (Blue_sig),
    .Hsync_out       (Hsync_out),
    .Vsync_out       (Vsync_out),
    .game_start      (game_start),
    .start_active    (start_active)
  );

  initial CLK_40M = 1'b0;
  always #12.5 CLK_40M = ~CLK_40M;

  // Synchronous image ROM: data one clock after the address.
  always @(posedge CLK_40M) rom_data <= romImg[rom_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: observed %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic resetModel();
    pipeEntry_t z;
    z = '0;
    mState = M_SHOW;
    mShowTicks = 0;
    mCountTicks = 0;
    mBlink = 1'b1;
    mPrevVs = 1'b0;
    mAddr = '0;
    expGameStart = 1'b0;
    expActive = 1'b0;
    pipeQ.delete();
    repeat (3) pipeQ.push_back(z);
  endtask

  task automatic toggleBlink();
`ifdef START_BLINK_EN
    mBlink = !mBlink;
`endif
  endtask

  // Called at a falling edge: check what the last rising edge produced, drive one pixel, advance the model.
  task automatic applyStimulus(input bit rdy, input int r, input int c, input bit h, input bit v,
                               input bit k, input bit go);
    pipeEntry_t e;
    bit inImg, pix, tick;
    int addr;
    if (pipeQ.size() == 3) begin
      e = pipeQ.pop_front();
      checkOutput("rgb", {16'd0, Red_sig, Green_sig, Blue_sig}, {16'd0, e.rgb});
      checkOutput("hsync", {31'd0, Hsync_out}, {31'd0, e.hs});
      checkOutput("vsync", {31'd0, Vsync_out}, {31'd0, e.vs});
    end
    checkOutput("romAddr", {16'd0, rom_addr}, {16'd0, mAddr});
    checkOutput("gameStart", {31'd0, game_start}, {31'd0, expGameStart});
    checkOutput("startActive", {31'd0, start_active}, {31'd0, expActive});

    start_Ready_sig = rdy;
    Row_add = 11'(r);
    Column_add = 11'(c);
    start_Hsync_sig = h;
    start_Vsync_sig = v;
    key_start = k;
    game_over = go;

    inImg = rdy && (c >= IMG_X0) && (c < IMG_X0 + IMG_W) && (r >= IMG_Y0) && (r < IMG_Y0 + IMG_H);
    addr = 0;
    if (inImg) begin
      addr = ((r - IMG_Y0) * IMG_W + (c - IMG_X0)) % 65536;
      mAddr = 16'(addr);
    end
    pix = inImg ? romImg[addr] : 1'b0;
    if (!rdy || mState == M_HIDDEN) e.rgb = 16'h0000;
    else if (!pix) e.rgb = RGB_BG;
    else if (r >= PROMPT_Y0 && r <= PROMPT_Y1) e.rgb = mBlink ? RGB_YELLOW : RGB_BG;
    else e.rgb = RGB_WHITE;
    e.hs = h;
    e.vs = v;
    pipeQ.push_back(e);

    tick = mPrevVs && !v;
    mPrevVs = v;
    expGameStart = 1'b0;
    case (mState)
      M_SHOW: begin
        if (k) begin
          mState = M_COUNT;
          mCountTicks = 0;
          mShowTicks = 0;
          mBlink = 1'b1;
        end else if (tick) begin
          mShowTicks++;
          if (mShowTicks == BLINK_FRAMES) begin
            mShowTicks = 0;
            toggleBlink();
          end
        end
      end
      M_COUNT: begin
        if (tick) begin
          mCountTicks++;
          if (mCountTicks == COUNT_FRAMES) begin
            mState = M_HIDDEN;
            expGameStart = 1'b1;
          end else if (mCountTicks % 4 == 0) begin
            toggleBlink();
          end
        end
      end
      default: begin
        if (go) begin
          mState = M_SHOW;
          mShowTicks = 0;
          mBlink = 1'b1;
        end
      end
    endcase
    expActive = (mState != M_HIDDEN);
    @(negedge CLK_40M);
  endtask

  // One short frame: random pixels, a known prompt-band pixel, Vsync dropping for the last two cycles.
  task automatic applyFrame(input int len, input int keyAt, input int overAt);
    bit v;
    for (int i = 0; i < len; i++) begin
      v = (i < len - 2);
      if (i == 1)
        applyStimulus(1'b1, 310, 300, 1'($urandom_range(0, 1)), v, keyAt == i, overAt == i);
      else
        applyStimulus($urandom_range(0, 7) != 0, $urandom_range(90, 370), $urandom_range(190, 470),
                      1'($urandom_range(0, 1)), v, keyAt == i, overAt == i);
    end
  endtask

  task automatic doReset(input int holdCycles);
    RSTn = 1'b0;
    start_Ready_sig = 1'b0;
    start_Hsync_sig = 1'b0;
    start_Vsync_sig = 1'b0;
    Row_add = '0;
    Column_add = '0;
    key_start = 1'b0;
    game_over = 1'b0;
    #1;
    checkOutput("rstRgb", {16'd0, Red_sig, Green_sig, Blue_sig}, 32'd0);
    checkOutput("rstSync", {30'd0, Hsync_out, Vsync_out}, 32'd0);
    checkOutput("rstRomAddr", {16'd0, rom_addr}, 32'd0);
    checkOutput("rstGameStart", {31'd0, game_start}, 32'd0);
    checkOutput("rstActive", {31'd0, start_active}, 32'd0);
    repeat (holdCycles) @(negedge CLK_40M);
    RSTn = 1'b1;
    resetModel();
  endtask

  initial begin
    int bCols[4];
    int bRows[4];
    compareCount = 0;
    failCount = 0;
    RSTn = 1'b1;
    for (int i = 0; i < 65536; i++) romImg[i] = 1'($urandom_range(0, 1));
    romImg[25137] = 1'b1;
    romImg[53347] = 1'b1;
    bCols = '{200, 201, 456, 457};
    bRows = '{101, 102, 354, 355};
    #2;
    doReset(3);

    applyStimulus(1'b1, 102, 201, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 103, 202, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("addr257", {16'd0, rom_addr}, 32'd257);
    applyStimulus(1'b1, 200, 250, 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    foreach (bRows[ri])
      foreach (bCols[ci])
        applyStimulus(1'b1, bRows[ri], bCols[ci], 1'b1, 1'b1, 1'b0, 1'b0);

    for (int f = 0; f < 62; f++) applyFrame(20, -1, (f == 5) ? 3 : -1);
    applyFrame(20, 18, -1);
    for (int f = 0; f < 65; f++) applyFrame(20, (f == 10) ? 5 : -1, (f == 12) ? 7 : -1);
    applyFrame(20, -1, 4);
    for (int f = 0; f < 3; f++) applyFrame(20, -1, -1);
    applyFrame(20, 2, -1);
    for (int f = 0; f < 30; f++) applyFrame(20, -1, -1);
    doReset(2);
    for (int f = 0; f < 35; f++) applyFrame(20, -1, -1);
    repeat (4) applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
